// File: rtl/writeback_arbiter_pkg.sv
// Shared uarch definitions for the writeback merge: field widths, the
// writeback-field struct, and a ring-index helper used by the grant search.
package writeback_arbiter_pkg;

  localparam int NUM_PIPES      = 5;
  localparam int SEQ_NUM_BITS   = 5;
  localparam int PHYS_ADDR_BITS = 6;
  localparam int XLEN           = 32;

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [SEQ_NUM_BITS-1:0]   seq_num;
    logic [PHYS_ADDR_BITS-1:0] waddr;
    logic [XLEN-1:0]           wdata;
    logic                      wen;
  } wb_fields_t;

  function automatic int pipe_idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // base + off wrapped into [0, n); off never exceeds n, so one subtract suffices.
  function automatic int ring_idx(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Purely combinational round-robin grant: search starts one past i_ptr and
// wraps; the first requesting pipe wins. Pointer state lives in the caller.
module rr_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int p_num = NUM_PIPES,
  localparam int LP_PTR_BITS = pipe_idx_bits(p_num)
) (
  input  logic [p_num-1:0]       i_req,
  input  logic [LP_PTR_BITS-1:0] i_ptr,
  output logic [p_num-1:0]       o_grant,
  output logic [LP_PTR_BITS-1:0] o_grant_idx,
  output logic                   o_any
);

  logic w_found;

  // Priority scan from (ptr+1) around the ring
  always_comb begin
    w_found     = 1'b0;
    o_grant     = '0;
    o_grant_idx = '0;
    for (int k = 1; k <= p_num; k++) begin
      if (!w_found && i_req[ring_idx(int'(i_ptr), k, p_num)]) begin
        w_found = 1'b1;
        o_grant[ring_idx(int'(i_ptr), k, p_num)] = 1'b1;
        o_grant_idx = LP_PTR_BITS'(ring_idx(int'(i_ptr), k, p_num));
      end else begin
        w_found = w_found;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges p_num_pipes execute result streams into one registered writeback
// stream. Optional perf counters are enabled with the WB_ARB_PERF_EN macro.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int p_num_pipes      = NUM_PIPES,
  parameter int p_seq_num_bits   = SEQ_NUM_BITS,
  parameter int p_phys_addr_bits = PHYS_ADDR_BITS,
  localparam int LP_PIPE_BITS    = pipe_idx_bits(p_num_pipes)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [p_num_pipes-1:0]                 ex_val,
  output logic [p_num_pipes-1:0]                 ex_rdy,
  input  logic [32*p_num_pipes-1:0]              ex_pc,
  input  logic [p_seq_num_bits*p_num_pipes-1:0]  ex_seq_num,
  input  logic [p_phys_addr_bits*p_num_pipes-1:0] ex_waddr,
  input  logic [32*p_num_pipes-1:0]              ex_wdata,
  input  logic [p_num_pipes-1:0]                 ex_wen,
  output logic                                   wb_val,
  input  logic                                   wb_rdy,
  output logic [31:0]                            wb_pc,
  output logic [p_seq_num_bits-1:0]              wb_seq_num,
  output logic [p_phys_addr_bits-1:0]            wb_waddr,
  output logic [31:0]                            wb_wdata,
  output logic                                   wb_wen,
  output logic [LP_PIPE_BITS-1:0]                wb_pipe
`ifdef WB_ARB_PERF_EN
  ,
  output logic [16*p_num_pipes-1:0]              perf_grant_cnt,
  output logic [15:0]                            perf_stall_cnt
`endif
);

  logic                    r_wb_val;
  wb_fields_t              r_wb;
  logic [LP_PIPE_BITS-1:0] r_wb_pipe;
  logic [LP_PIPE_BITS-1:0] r_last_grant;

  logic [p_num_pipes-1:0]  w_grant;
  logic [LP_PIPE_BITS-1:0] w_grant_idx;
  logic                    w_any;
  logic                    w_can_accept;
  logic                    w_ex_xfer;
  wb_fields_t              w_sel;

  rr_arbiter #(
    .p_num(p_num_pipes)
  ) u_rr (
    .i_req      (ex_val),
    .i_ptr      (r_last_grant),
    .o_grant    (w_grant),
    .o_grant_idx(w_grant_idx),
    .o_any      (w_any)
  );

  // Reset gates acceptance so nothing transfers during a reset cycle.
  assign w_can_accept = rst && (!r_wb_val || wb_rdy);
  assign w_ex_xfer    = w_can_accept && w_any;
  assign ex_rdy       = {p_num_pipes{w_can_accept}} & w_grant;

  // Field mux for the granted pipe
  always_comb begin
    w_sel         = '0;
    w_sel.pc      = ex_pc[int'(w_grant_idx)*32 +: 32];
    w_sel.seq_num = ex_seq_num[int'(w_grant_idx)*p_seq_num_bits +: p_seq_num_bits];
    w_sel.waddr   = ex_waddr[int'(w_grant_idx)*p_phys_addr_bits +: p_phys_addr_bits];
    w_sel.wdata   = ex_wdata[int'(w_grant_idx)*32 +: 32];
    w_sel.wen     = ex_wen[w_grant_idx];
  end

  // Output-valid flag and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_val     <= 1'b0;
      r_last_grant <= LP_PIPE_BITS'(p_num_pipes - 1);
    end else if (w_ex_xfer) begin
      r_wb_val     <= 1'b1;
      r_last_grant <= w_grant_idx;
    end else if (wb_rdy) begin
      r_wb_val     <= 1'b0;
    end else begin
      r_wb_val     <= r_wb_val;
    end
  end

  // Payload register; contents are meaningless while r_wb_val is low
  always_ff @(posedge clk) begin
    if (w_ex_xfer) begin
      r_wb      <= w_sel;
      r_wb_pipe <= w_grant_idx;
    end
  end

  assign wb_val     = r_wb_val;
  assign wb_pc      = r_wb.pc;
  assign wb_seq_num = r_wb.seq_num;
  assign wb_waddr   = r_wb.waddr;
  assign wb_wdata   = r_wb.wdata;
  assign wb_wen     = r_wb.wen;
  assign wb_pipe    = r_wb_pipe;

`ifdef WB_ARB_PERF_EN
  logic [15:0] r_grant_cnt [p_num_pipes];
  logic [15:0] r_stall_cnt;

  // Saturating per-pipe grant and output-stall counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < p_num_pipes; i++) begin
        r_grant_cnt[i] <= 16'd0;
      end
      r_stall_cnt <= 16'd0;
    end else begin
      for (int i = 0; i < p_num_pipes; i++) begin
        if (w_ex_xfer && w_grant[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
        end
      end
      if (r_wb_val && !wb_rdy && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < p_num_pipes; g++) begin : g_perf
    assign perf_grant_cnt[16*g +: 16] = r_grant_cnt[g];
  end
  assign perf_stall_cnt = r_stall_cnt;
`endif

`ifndef SYNTHESIS
  string w_trace;

  // Fixed-width "<pipe>:<seq>" trace, blank when idle
  always_comb begin
    if (r_wb_val) begin
      w_trace = $sformatf("%1d:%2d", r_wb_pipe, r_wb.seq_num);
    end else begin
      w_trace = "    ";
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: stimulus pushes expected results into
// a scoreboard queue, a negedge monitor pops and compares on each wb transfer.
module tb_writeback_arbiter;

  localparam int N = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ex_val;
  logic [N-1:0]    ex_rdy;
  logic [32*N-1:0] ex_pc;
  logic [5*N-1:0]  ex_seq_num;
  logic [6*N-1:0]  ex_waddr;
  logic [32*N-1:0] ex_wdata;
  logic [N-1:0]    ex_wen;
  logic            wb_val;
  logic            wb_rdy;
  logic [31:0]     wb_pc;
  logic [4:0]      wb_seq_num;
  logic [5:0]      wb_waddr;
  logic [31:0]     wb_wdata;
  logic            wb_wen;
  logic [2:0]      wb_pipe;
`ifdef WB_ARB_PERF_EN
  logic [16*N-1:0] perf_grant_cnt;
  logic [15:0]     perf_stall_cnt;
`endif

  logic [31:0] f_pc    [N];
  logic [4:0]  f_seq   [N];
  logic [5:0]  f_waddr [N];
  logic [31:0] f_wdata [N];
  logic        f_wen   [N];

  typedef struct packed {
    logic [2:0]  pipe;
    logic [31:0] pc;
    logic [4:0]  seq;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_item;
  exp_t act_item;
  int   n_tests = 0;
  int   n_fail  = 0;

  writeback_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .ex_val    (ex_val),
    .ex_rdy    (ex_rdy),
    .ex_pc     (ex_pc),
    .ex_seq_num(ex_seq_num),
    .ex_waddr  (ex_waddr),
    .ex_wdata  (ex_wdata),
    .ex_wen    (ex_wen),
    .wb_val    (wb_val),
    .wb_rdy    (wb_rdy),
    .wb_pc     (wb_pc),
    .wb_seq_num(wb_seq_num),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .wb_wen    (wb_wen),
    .wb_pipe   (wb_pipe)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_grant_cnt(perf_grant_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ex_pc[32*i +: 32]    = f_pc[i];
      ex_seq_num[5*i +: 5] = f_seq[i];
      ex_waddr[6*i +: 6]   = f_waddr[i];
      ex_wdata[32*i +: 32] = f_wdata[i];
      ex_wen[i]            = f_wen[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int p);
    exp_t e;
    e.pipe  = 3'(p);
    e.pc    = f_pc[p];
    e.seq   = f_seq[p];
    e.waddr = f_waddr[p];
    e.wdata = f_wdata[p];
    e.wen   = f_wen[p];
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every wb transfer must match the oldest expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && wb_val === 1'b1 && wb_rdy === 1'b1) begin
      n_tests++;
      act_item = '{wb_pipe, wb_pc, wb_seq_num, wb_waddr, wb_wdata, wb_wen};
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pipe %0d seq %0d with empty scoreboard", wb_pipe, wb_seq_num);
      end else begin
        exp_item = sb_q.pop_front();
        if (act_item !== exp_item) begin
          n_fail++;
          $display("FAIL sb_item: got %0h expected %0h", act_item, exp_item);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      f_pc[i]    = 32'h0000_1000 + 32'(i) * 32'h10;
      f_seq[i]   = 5'(i + 1);
      f_waddr[i] = 6'(3 * i + 1);
      f_wdata[i] = 32'hA5A5_0000 | 32'(i);
      f_wen[i]   = 1'(i % 2);
    end
    rst    = 1'b0;
    ex_val = 5'b11111;
    wb_rdy = 1'b1;

    // Reset holds everything quiet
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("reset_ex_rdy", 64'(ex_rdy), 64'd0);
      check("reset_wb_val", 64'(wb_val), 64'd0);
    end
    next_cycle();
    rst = 1'b1;

    // Fairness: all pipes valid, wb_rdy high
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("fair_grant", 64'(ex_rdy), 64'(5'd1 << (k % 5)));
      if (k > 0) check("fair_wb_val", 64'(wb_val), 64'd1);
      push(k % 5);
      next_cycle();
    end
    ex_val = 5'b00000;
    @(negedge clk);
    check("fair_last_val", 64'(wb_val), 64'd1);
    next_cycle();
    @(negedge clk);
    check("fair_drained", 64'(wb_val), 64'd0);
`ifdef WB_ARB_PERF_EN
    for (int i = 0; i < N; i++) begin
      check("perf_grant", 64'(perf_grant_cnt[16*i +: 16]), 64'd2);
    end
`endif

    // Backpressure: pipe 2 result held while wb_rdy is low
    next_cycle();
    f_pc[2] = 32'h0000_2000; f_seq[2] = 5'd7; f_waddr[2] = 6'd9;
    f_wdata[2] = 32'hDEAD_BEEF; f_wen[2] = 1'b1;
    ex_val = 5'b00100;
    @(negedge clk);
    check("bp_grant", 64'(ex_rdy), 64'(5'b00100));
    push(2);
    next_cycle();
    wb_rdy = 1'b0;
    f_pc[2] = 32'h0000_2004; f_seq[2] = 5'd8; f_wdata[2] = 32'h1234_5678;
    push(2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_no_rdy", 64'(ex_rdy), 64'd0);
      check("bp_hold_val", 64'(wb_val), 64'd1);
      check("bp_hold_seq", 64'(wb_seq_num), 64'd7);
      check("bp_hold_data", 64'(wb_wdata), 64'hDEAD_BEEF);
      check("bp_hold_pipe", 64'(wb_pipe), 64'd2);
      next_cycle();
    end
    wb_rdy = 1'b1;
    @(negedge clk);
    check("bp_resume", 64'(ex_rdy), 64'(5'b00100));
    next_cycle();
    ex_val = 5'b00000;
    @(negedge clk);
    check("bp_second_seq", 64'(wb_seq_num), 64'd8);
`ifdef WB_ARB_PERF_EN
    check("perf_stall", 64'(perf_stall_cnt), 64'd3);
`endif

    // Wrap: bring pointer to 4, then pipes 0 and 4 compete
    next_cycle();
    ex_val = 5'b10000;
    @(negedge clk);
    check("wrap_setup", 64'(ex_rdy), 64'(5'b10000));
    push(4);
    next_cycle();
    ex_val = 5'b10001;
    @(negedge clk);
    check("wrap_pipe0", 64'(ex_rdy), 64'(5'b00001));
    push(0);
    next_cycle();
    @(negedge clk);
    check("wrap_pipe4", 64'(ex_rdy), 64'(5'b10000));
    push(4);
    next_cycle();
    ex_val = 5'b00000;
    next_cycle();
    next_cycle();

    // Sparse: single pipe 3 result
    f_waddr[3] = 6'd12; f_wen[3] = 1'b1;
    ex_val = 5'b01000;
    @(negedge clk);
    check("sparse_grant", 64'(ex_rdy), 64'(5'b01000));
    check("sparse_idle", 64'(wb_val), 64'd0);
    push(3);
    next_cycle();
    ex_val = 5'b00000;
    @(negedge clk);
    check("sparse_val", 64'(wb_val), 64'd1);
    check("sparse_pipe", 64'(wb_pipe), 64'd3);
    check("sparse_waddr", 64'(wb_waddr), 64'd12);
    next_cycle();
    @(negedge clk);
    check("sparse_drained", 64'(wb_val), 64'd0);

    // Reset mid-operation discards the held result and resets priority
    next_cycle();
    wb_rdy = 1'b0;
    ex_val = 5'b00001;
    @(negedge clk);
    check("midrst_grant", 64'(ex_rdy), 64'(5'b00001));
    next_cycle();
    rst = 1'b0;
    ex_val = 5'b11111;
    @(negedge clk);
    check("midrst_no_rdy", 64'(ex_rdy), 64'd0);
    check("midrst_held", 64'(wb_val), 64'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cleared", 64'(wb_val), 64'd0);
    check("midrst_ptr", 64'(ex_rdy), 64'(5'b00001));
    push(0);
    next_cycle();
    ex_val = 5'b00000;
    wb_rdy = 1'b1;

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
